// File: rtl/rom_load_sequencer_pkg.sv
// rom_load_pkg: shared types and constants for the ROM download sequencer.
//   - state_t      : sequencer FSM states
//   - REGION_BASE  : first download byte of each ROM region (Ninja-Kun map)
//   - REGION_SIZE  : byte size of each ROM region (unused slots are size 0)
//   - ERR_RANGE/ERR_SIZE : bit positions inside the ERR status field
package rom_load_pkg;

    localparam int unsigned ADDR_W     = 25;
    localparam int unsigned REGION_MAX = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DRAIN,
        HOLD,
        RUN,
        FAIL
    } state_t;

    // Index order 7..0; entries 0..3 are main CPU, sub CPU, FG tiles, BG/sprite tiles.
    localparam logic [REGION_MAX-1:0][ADDR_W-1:0] REGION_BASE = {
        25'h0, 25'h0, 25'h0, 25'h0,
        25'h0_C000, 25'h0_8000, 25'h0_4000, 25'h0_0000
    };

    localparam logic [REGION_MAX-1:0][ADDR_W-1:0] REGION_SIZE = {
        25'h0, 25'h0, 25'h0, 25'h0,
        25'h0_6000, 25'h0_4000, 25'h0_4000, 25'h0_4000
    };

    localparam int unsigned ERR_RANGE = 0;
    localparam int unsigned ERR_SIZE  = 1;

endpackage

// File: rtl/rom_load_sequencer_if.sv
// rom_load_sequencer_if: ioctl download stream, ROM write port and core status.
//   master : the sequencer (consumes DL_* and ROM_BUSY, drives the rest)
//   slave  : the surrounding system (hps_io / ROM port / core)
// Optional macro ROM_CHECKSUM_EN adds the CSUM status bus.
interface rom_load_sequencer_if
    import rom_load_pkg::*;
#(
    parameter int unsigned NREG = 4,
    parameter int unsigned AW   = 17
);
    logic              DL_ACT;
    logic              DL_WR;
    logic [ADDR_W-1:0] DL_AD;
    logic [7:0]        DL_DT;
    logic              DL_WAIT;
    logic              ROM_BUSY;
    logic [NREG-1:0]   ROMEN;
    logic [AW-1:0]     ROMAD;
    logic [7:0]        ROMDT;
    logic              CORE_RST;
    logic              LOAD_OK;
    logic [1:0]        ERR;
`ifdef ROM_CHECKSUM_EN
    logic [15:0]       CSUM;
`endif

    modport master (
        input  DL_ACT, DL_WR, DL_AD, DL_DT, ROM_BUSY,
        output DL_WAIT, ROMEN, ROMAD, ROMDT, CORE_RST, LOAD_OK, ERR
`ifdef ROM_CHECKSUM_EN
        , output CSUM
`endif
    );

    modport slave (
        output DL_ACT, DL_WR, DL_AD, DL_DT, ROM_BUSY,
        input  DL_WAIT, ROMEN, ROMAD, ROMDT, CORE_RST, LOAD_OK, ERR
`ifdef ROM_CHECKSUM_EN
        , input CSUM
`endif
    );

endinterface

// File: rtl/rom_load_sequencer_region_decode.sv
// rom_region_decode: maps a linear download address onto a ROM region.
//   ad       : linear download byte address
//   sel      : one-hot region select (all zero when out of range)
//   local_ad : address relative to the selected region base
//   in_range : ad falls inside one of the first NREG regions
module rom_region_decode
    import rom_load_pkg::*;
#(
    parameter int unsigned NREG = 4,
    parameter int unsigned AW   = 17
) (
    input  logic [ADDR_W-1:0] ad,
    output logic [NREG-1:0]   sel,
    output logic [AW-1:0]     local_ad,
    output logic              in_range
);

    logic [NREG-1:0]         hit;
    logic [NREG:0][AW-1:0]   acc;

    assign acc[0] = '0;

    // Regions never overlap, so the per-region hits are already one-hot.
    for (genvar g = 0; g < NREG; g++) begin : g_region
        localparam logic [ADDR_W-1:0] BASE = REGION_BASE[g];
        localparam logic [ADDR_W-1:0] SIZE = REGION_SIZE[g];
        logic [ADDR_W-1:0] off;

        assign off        = ad - BASE;
        assign hit[g]     = (ad >= BASE) && (off < SIZE);
        assign acc[g + 1] = acc[g] | (hit[g] ? AW'(off) : '0);
    end

    assign sel      = hit;
    assign local_ad = acc[NREG];
    assign in_range = |hit;

endmodule

// File: rtl/rom_load_sequencer.sv
// rom_load_sequencer: turns the hps_io ioctl download into ROM region writes
// and owns the game-core reset.
//   MCLK, RESET_N : system clock, asynchronous active-low reset
//   bus (master)  : DL_ACT/DL_WR/DL_AD/DL_DT in, DL_WAIT out (HPS side);
//                   ROM_BUSY in, ROMEN/ROMAD/ROMDT out (ROM port);
//                   CORE_RST, LOAD_OK, ERR out (status)
// Optional macro ROM_CHECKSUM_EN adds IMG_SUM and the CSUM output; a checksum
// mismatch then fails the image exactly like a size mismatch.
module rom_load_sequencer
    import rom_load_pkg::*;
#(
    parameter int unsigned       NREG     = 4,
    parameter logic [ADDR_W-1:0] IMG_SIZE = 25'h1_2000,
    parameter int unsigned       RST_HOLD = 16,
    parameter int unsigned       AW       = 17
`ifdef ROM_CHECKSUM_EN
    ,
    parameter logic [15:0]       IMG_SUM  = 16'h0000
`endif
) (
    input  logic                 MCLK,
    input  logic                 RESET_N,
    rom_load_sequencer_if.master bus
);

    localparam int unsigned HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

    state_t            state_q, state_d;
    logic              dl_act_q;
    logic              pend_q;
    logic [NREG-1:0]   pend_sel_q;
    logic [AW-1:0]     pend_ad_q;
    logic [7:0]        pend_dt_q;
    logic [NREG-1:0]   romen_q;
    logic [AW-1:0]     romad_q;
    logic [7:0]        romdt_q;
    logic              dl_wait_q;
    logic              core_rst_q;
    logic              load_ok_q;
    logic [1:0]        err_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [HOLD_W-1:0] hold_q;

    logic [NREG-1:0]   dec_sel;
    logic [AW-1:0]     dec_ad;
    logic              dec_hit;

    logic start_c, wr_ok_c, new_c, bad_c, have_c, fire_c;
    logic drained_c, hold_done_c, img_bad_c;

    rom_region_decode #(
        .NREG (NREG),
        .AW   (AW)
    ) u_decode (
        .ad       (bus.DL_AD),
        .sel      (dec_sel),
        .local_ad (dec_ad),
        .in_range (dec_hit)
    );

    // A rising DL_ACT starts a load; a byte in that same cycle belongs to it.
    assign start_c     = bus.DL_ACT && !dl_act_q &&
                         (state_q == IDLE || state_q == RUN || state_q == FAIL);
    assign wr_ok_c     = bus.DL_WR && bus.DL_ACT && (state_q == LOAD || start_c);
    assign new_c       = wr_ok_c && dec_hit && !pend_q;
    assign bad_c       = wr_ok_c && (!dec_hit || pend_q);
    // ROM_BUSY is sampled one cycle ahead of the registered write strobe.
    assign have_c      = pend_q || new_c;
    assign fire_c      = have_c && !bus.ROM_BUSY;
    assign drained_c   = (state_q == DRAIN) && !pend_q;
    assign hold_done_c = (state_q == HOLD) && (hold_q == '0);

`ifdef ROM_CHECKSUM_EN
    logic [15:0] csum_q;

    assign img_bad_c = (cnt_q != IMG_SIZE) || (csum_q != IMG_SUM);
    assign bus.CSUM  = csum_q;

    // Running sum of accepted in-range bytes for the current load.
    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            csum_q <= '0;
        end else if (start_c) begin
            csum_q <= new_c ? 16'(bus.DL_DT) : '0;
        end else if (new_c) begin
            csum_q <= csum_q + 16'(bus.DL_DT);
        end
    end
`else
    assign img_bad_c = (cnt_q != IMG_SIZE);
`endif

    // State register.
    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, RUN, FAIL: if (start_c) state_d = LOAD;
            LOAD:            if (!bus.DL_ACT) state_d = DRAIN;
            DRAIN:           if (!pend_q) state_d = (err_q[ERR_RANGE] || img_bad_c) ? FAIL : HOLD;
            HOLD:            if (hold_q == '0) state_d = RUN;
            default:         state_d = IDLE;
        endcase
    end

    // Pending buffer, ROM port, byte counter, status and reset hold.
    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            dl_act_q   <= 1'b0;
            pend_q     <= 1'b0;
            pend_sel_q <= '0;
            pend_ad_q  <= '0;
            pend_dt_q  <= '0;
            romen_q    <= '0;
            romad_q    <= '0;
            romdt_q    <= '0;
            dl_wait_q  <= 1'b0;
            core_rst_q <= 1'b1;
            load_ok_q  <= 1'b0;
            err_q      <= '0;
            cnt_q      <= '0;
            hold_q     <= '0;
        end else begin
            dl_act_q   <= bus.DL_ACT;
            core_rst_q <= (state_d != RUN);
            dl_wait_q  <= have_c;
            pend_q     <= have_c && bus.ROM_BUSY;

            if (new_c) begin
                pend_sel_q <= dec_sel;
                pend_ad_q  <= dec_ad;
                pend_dt_q  <= bus.DL_DT;
            end

            romen_q <= '0;
            if (fire_c) begin
                romen_q <= pend_q ? pend_sel_q : dec_sel;
                romad_q <= pend_q ? pend_ad_q  : dec_ad;
                romdt_q <= pend_q ? pend_dt_q  : bus.DL_DT;
            end

            // Every byte offered during a load is counted, dropped or not.
            if (start_c) begin
                cnt_q <= wr_ok_c ? ADDR_W'(1) : '0;
            end else if (wr_ok_c && (cnt_q != '1)) begin
                cnt_q <= cnt_q + ADDR_W'(1);
            end

            if (start_c) begin
                err_q            <= '0;
                err_q[ERR_RANGE] <= bad_c;
                load_ok_q        <= 1'b0;
            end else begin
                if (bad_c) err_q[ERR_RANGE] <= 1'b1;
                if (drained_c) err_q[ERR_SIZE] <= img_bad_c;
                if (hold_done_c) load_ok_q <= 1'b1;
            end

            if (drained_c) begin
                hold_q <= HOLD_W'(RST_HOLD - 1);
            end else if (state_q == HOLD && hold_q != '0) begin
                hold_q <= hold_q - HOLD_W'(1);
            end
        end
    end

    assign bus.ROMEN    = romen_q;
    assign bus.ROMAD    = romad_q;
    assign bus.ROMDT    = romdt_q;
    assign bus.DL_WAIT  = dl_wait_q;
    assign bus.CORE_RST = core_rst_q;
    assign bus.LOAD_OK  = load_ok_q;
    assign bus.ERR      = err_q;

endmodule
